ysyx_22040632_ifu: RTL and testbench

//  Instruction fetch unit; the producer end of the decoder's inst/pc interface.

---
 rtl/ysyx_22040632_ifu.sv | 133 +++++++++++++
 tb/tb_ysyx_22040632_ifu.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22040632_ifu.sv
`timescale 1ns/1ps
// Instruction fetch unit: keeps the architectural PC, issues one imem fetch at a time,
// hands each instruction to the IDU over valid/ready and squashes wrong-path fetches.
module ysyx_22040632_ifu #(
  parameter int unsigned     XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(64'h8000_0000)
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [63:0]     fetch_count
);

  localparam int unsigned INST_W = 32;
  localparam int unsigned CNT_W  = 64;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  logic [1:0]        r_state;
  logic [XLEN-1:0]   r_pc;
  logic              r_kill;
  logic [INST_W-1:0] r_inst;
  logic [XLEN-1:0]   r_inst_pc;
  logic [CNT_W-1:0]  r_count;
  logic              r_req_valid;
  logic              r_inst_valid;

  logic [1:0]        w_state_nxt;
  logic [XLEN-1:0]   w_pc_nxt;
  logic              w_kill_nxt;
  logic [INST_W-1:0] w_inst_nxt;
  logic [XLEN-1:0]   w_inst_pc_nxt;
  logic [CNT_W-1:0]  w_count_nxt;
  logic [XLEN-1:0]   w_redir_pc;
  logic [XLEN-1:0]   w_pc_inc;

  // Redirect targets are forced word-aligned so the PC never leaves 4-byte alignment.
  assign w_redir_pc = redirect_pc & ~XLEN'(3);
  assign w_pc_inc   = r_pc + XLEN'(4);

  // Next-state and datapath updates; a redirect outranks every other event.
  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_kill_nxt    = r_kill;
    w_inst_nxt    = r_inst;
    w_inst_pc_nxt = r_inst_pc;
    w_count_nxt   = r_count;
    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_REQ;
        if (redirect_valid) w_pc_nxt = w_redir_pc;
      end
      S_REQ: begin
        if (imem_req_ready) w_state_nxt = S_WAIT;
        if (redirect_valid) begin
          w_pc_nxt   = w_redir_pc;
          w_kill_nxt = imem_req_ready;
        end
      end
      S_WAIT: begin
        if (imem_resp_valid) begin
          w_kill_nxt = 1'b0;
          if (redirect_valid || r_kill) begin
            w_state_nxt = S_REQ;
          end else begin
            w_inst_nxt    = imem_resp_data;
            w_inst_pc_nxt = r_pc;
            w_state_nxt   = S_HOLD;
          end
        end else if (redirect_valid) begin
          w_kill_nxt = 1'b1;
        end
        if (redirect_valid) w_pc_nxt = w_redir_pc;
      end
      S_HOLD: begin
        if (redirect_valid) begin
          w_pc_nxt    = w_redir_pc;
          w_state_nxt = S_REQ;
        end else if (inst_ready) begin
          w_pc_nxt    = w_pc_inc;
          w_count_nxt = r_count + CNT_W'(1);
          w_state_nxt = S_REQ;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register; handshake valids are registered copies of the next-state decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC;
      r_kill       <= 1'b0;
      r_inst       <= '0;
      r_inst_pc    <= '0;
      r_count      <= '0;
      r_req_valid  <= 1'b0;
      r_inst_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_kill       <= w_kill_nxt;
      r_inst       <= w_inst_nxt;
      r_inst_pc    <= w_inst_pc_nxt;
      r_count      <= w_count_nxt;
      r_req_valid  <= (w_state_nxt == S_REQ);
      r_inst_valid <= (w_state_nxt == S_HOLD);
    end
  end

  assign imem_req_valid = r_req_valid;
  assign imem_addr      = r_pc;
  assign inst_valid     = r_inst_valid;
  assign inst           = r_inst;
  assign inst_pc        = r_inst_pc;
  assign fetch_count    = r_count;

endmodule

// File: tb/tb_ysyx_22040632_ifu.sv
`timescale 1ns/1ps
// Scoreboard bench for the IFU: memory and IDU models driven by $urandom knobs,
// expected fetch stream derived from "next PC = last target or previous PC + 4".
module tb_ysyx_22040632_ifu;

  localparam logic [63:0] RST_PC = 64'h8000_0000;
  localparam logic [2:0] ID_ADDR = 3'd0, ID_CNT = 3'd1, ID_IPC = 3'd2;
  localparam logic [2:0] ID_REQV = 3'd3, ID_INSTV = 3'd4, ID_TO = 3'd5;

  typedef struct packed {
    logic [2:0]  id;
    logic [63:0] val;
  } dexp_t;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic [63:0] fetch_count;

  ysyx_22040632_ifu u_dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_addr       (imem_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst            (inst),
    .inst_pc         (inst_pc),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .fetch_count     (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  int          n_timeout = 0;
  int          addr_age = 0;
  logic [63:0] model_cnt = 64'd0;
  logic [63:0] exp_q[$];
  dexp_t       dq[$];
  bit          stall_prev = 1'b0;
  bit          prev_rst = 1'b0;

  int unsigned rdy_pct = 100, cons_pct = 100, rd_pct = 0, dly_lo = 0, dly_hi = 0;

  logic        m_pend = 1'b0;
  int          m_wait = 0;
  logic [63:0] m_addr = 64'd0;
  logic        nx_rv = 1'b0;
  logic [31:0] nx_rd = 32'd0;

  // Instruction memory contents: a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] * 32'h9E37_79B1 + a[63:32];
  endfunction

  function automatic logic [63:0] rand_target();
    logic [63:0] t;
    t = 64'h8000_0000 + 64'($urandom_range(4095, 0));
    if ($urandom_range(7, 0) == 0) t = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(15, 0));
    return t;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  // Monitor, scoreboard and memory model, all sampled mid-cycle.
  always @(negedge clk) begin
    logic [63:0] e;
    if (rst) begin
      exp_q.delete();
      exp_q.push_back(RST_PC);
      model_cnt  = 64'd0;
      stall_prev = 1'b0;
      prev_rst   = 1'b1;
      if (m_pend) m_wait = 0;
    end else begin
      if (prev_rst) begin
        check("rst_req_valid", 64'(imem_req_valid), 64'd0);
        check("rst_inst_valid", 64'(inst_valid), 64'd0);
        check("rst_inst", 64'(inst), 64'd0);
        check("rst_inst_pc", inst_pc, 64'd0);
      end
      prev_rst = 1'b0;
      check("fetch_count", fetch_count, model_cnt);
      check("req_inst_excl", 64'(imem_req_valid & inst_valid), 64'd0);
      if (stall_prev) check("hold_valid", 64'(inst_valid), 64'd1);
      if (inst_valid) begin
        check("inst_pc", inst_pc, exp_q[0]);
        check("inst", 64'(inst), 64'(mem_word(exp_q[0])));
      end
      if (imem_req_valid) check("req_addr", imem_addr, exp_q[0]);
      if (imem_req_valid && imem_req_ready) begin
        check("one_outstanding", 64'(m_pend), 64'd0);
        m_pend = 1'b1;
        m_wait = int'($urandom_range(dly_hi, dly_lo));
        m_addr = imem_addr;
      end
      while (dq.size() != 0) begin
        if (dq[0].id == ID_ADDR && !imem_req_valid) begin
          addr_age++;
          if (addr_age > 150) begin
            total++;
            bad++;
            $display("FAIL dir_addr: no request seen, want %h", dq[0].val);
            dq.delete(0);
            addr_age = 0;
          end
          break;
        end
        addr_age = 0;
        case (dq[0].id)
          ID_ADDR:  check("dir_addr", imem_addr, dq[0].val);
          ID_CNT:   check("dir_count", fetch_count, dq[0].val);
          ID_IPC:   check("dir_inst_pc", inst_pc, dq[0].val);
          ID_REQV:  check("dir_req_valid", 64'(imem_req_valid), dq[0].val);
          ID_INSTV: check("dir_inst_valid", 64'(inst_valid), dq[0].val);
          default:  check("wait_timeouts", 64'(n_timeout), dq[0].val);
        endcase
        dq.delete(0);
      end
      if (inst_valid && inst_ready && !redirect_valid) begin
        e = exp_q[0];
        exp_q.delete(0);
        exp_q.push_back(e + 64'd4);
        model_cnt = model_cnt + 64'd1;
      end
      stall_prev = inst_valid && !inst_ready && !redirect_valid;
      if (redirect_valid) begin
        exp_q.delete();
        exp_q.push_back(redirect_pc & ~64'd3);
      end
    end
    nx_rv = 1'b0;
    nx_rd = $urandom();
    if (m_pend) begin
      if (m_wait == 0) begin
        nx_rv  = 1'b1;
        nx_rd  = mem_word(m_addr);
        m_pend = 1'b0;
      end else begin
        m_wait--;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    imem_resp_valid = nx_rv;
    imem_resp_data  = nx_rd;
    imem_req_ready  = ($urandom_range(99, 0) < rdy_pct);
    inst_ready      = ($urandom_range(99, 0) < cons_pct);
    redirect_valid  = 1'b0;
    if ($urandom_range(99, 0) < rd_pct) begin
      redirect_valid = 1'b1;
      redirect_pc    = rand_target();
    end
  endtask

  task automatic push_d(input logic [2:0] id, input logic [63:0] val);
    dexp_t d;
    d.id  = id;
    d.val = val;
    dq.push_back(d);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (dq.size() != 0 && k < 300) begin step(); k++; end
    if (dq.size() != 0) n_timeout++;
  endtask

  task automatic wait_req(input bit need_acc);
    int k;
    k = 0;
    while (!(imem_req_valid && (imem_req_ready || !need_acc)) && k < 60) begin step(); k++; end
    if (!(imem_req_valid && (imem_req_ready || !need_acc))) n_timeout++;
  endtask

  task automatic wait_inst();
    int k;
    k = 0;
    while (!inst_valid && k < 60) begin step(); k++; end
    if (!inst_valid) n_timeout++;
  endtask

  initial begin
    int k;
    logic [63:0] c0;
    rst = 1'b1;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = 32'd0;
    inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 64'd0;
    step(); step();
    rst = 1'b0;

    // Streaming with an always-ready memory and consumer: three sequential fetches.
    k = 0;
    while (model_cnt < 64'd3 && k < 60) begin step(); k++; end
    if (model_cnt < 64'd3) n_timeout++;
    push_d(ID_CNT, 64'd3);

    // Consumer stalls five cycles in HOLD.
    cons_pct = 0;
    wait_inst();
    repeat (5) step();
    push_d(ID_IPC, 64'h8000_000C);
    push_d(ID_CNT, 64'd3);
    push_d(ID_REQV, 64'd0);
    push_d(ID_INSTV, 64'd1);

    // Redirect while a slow response is outstanding.
    cons_pct = 100; dly_lo = 3; dly_hi = 3;
    wait_req(1'b1);
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0100;
    push_d(ID_ADDR, 64'h8000_0100);
    drain();

    // Redirect in HOLD together with inst_ready: instruction discarded.
    cons_pct = 0; dly_lo = 0; dly_hi = 1;
    wait_inst();
    c0 = model_cnt;
    inst_ready     = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0200;
    step();
    push_d(ID_ADDR, 64'h8000_0200);
    push_d(ID_CNT, c0);
    drain();

    // Misaligned redirect coinciding with the request handshake.
    cons_pct = 100; rdy_pct = 100; dly_lo = 1; dly_hi = 1;
    wait_req(1'b0);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0102;
    step();
    push_d(ID_ADDR, 64'h8000_0100);
    drain();

    // Reset during WAIT with the stale response arriving right after.
    dly_lo = 2; dly_hi = 2;
    wait_req(1'b1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    push_d(ID_CNT, 64'd0);
    push_d(ID_ADDR, RST_PC);
    drain();

    // PC wrap at the top of the address space.
    dly_lo = 0; dly_hi = 2;
    wait_req(1'b0);
    redirect_valid = 1'b1;
    redirect_pc    = 64'hFFFF_FFFF_FFFF_FFF8;
    step();
    push_d(ID_ADDR, 64'hFFFF_FFFF_FFFF_FFF8);
    drain();
    repeat (20) step();

    // Randomised traffic with occasional resets.
    for (int b = 0; b < 8; b++) begin
      rdy_pct  = $urandom_range(100, 20);
      cons_pct = $urandom_range(100, 20);
      rd_pct   = $urandom_range(10, 0);
      dly_lo   = 0;
      dly_hi   = $urandom_range(3, 0);
      for (int i = 0; i < 400; i++) begin
        if ($urandom_range(399, 0) == 0) begin
          rst = 1'b1;
          step();
          rst = 1'b0;
        end else begin
          step();
        end
      end
    end

    rd_pct = 0; rdy_pct = 100; cons_pct = 100;
    push_d(ID_TO, 64'd0);
    drain();
    repeat (3) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
